// File: rtl/forward_scoreboard.sv
// Operand-forwarding scoreboard: tracks destination tags of DEPTH post-EX stages and
// picks forward sources / load-use stalls for EX. Optional stall counter: FWD_STALL_CNT_EN.
module forward_scoreboard #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 3,
  localparam int SELW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rs1,
  input  logic [4:0]      ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_late,
  input  logic            flush,
  output logic [SELW-1:0] fwd_a,
  output logic [SELW-1:0] fwd_b,
  output logic            stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  if (DEPTH < 2 || DEPTH > 6 || XLEN < 1) begin : g_param_check
    $error("forward_scoreboard: DEPTH must be 2..6 and XLEN positive");
  end

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] late_q, late_d;
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];

  logic             ex_active;
  logic             load_en;
  logic [4:0]       src [2];

  assign src[0]    = ex_rs1;
  assign src[1]    = ex_rs2;
  assign ex_active = ex_valid && !flush;

  // Youngest match wins; only a late producer still in stage 0 is not yet ready.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic [SELW-1:0] sel;
    logic            not_ready;

    always_comb begin
      sel       = '0;
      not_ready = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (valid_q[i] && rd_q[i] == src[gi]) begin
          not_ready = late_q[i] && (i == 0);
          sel       = (late_q[i] && (i == 0)) ? '0 : SELW'(i + 1);
        end
      end
      if (src[gi] == 5'd0) begin
        sel       = '0;
        not_ready = 1'b0;
      end
    end
  end

  assign stall   = ex_active && (g_src[0].not_ready || g_src[1].not_ready);
  assign fwd_a   = ex_active ? g_src[0].sel : '0;
  assign fwd_b   = ex_active ? g_src[1].sel : '0;
  assign load_en = ex_valid && ex_regwrite && (ex_rd != 5'd0) && !stall && !flush;

  assign valid_d[0] = load_en;
  assign late_d[0]  = ex_late;
  assign rd_d[0]    = ex_rd;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
    assign valid_d[gi] = valid_q[gi-1];
    assign late_d[gi]  = late_q[gi-1];
    assign rd_d[gi]    = rd_q[gi-1];
  end

  // Only the valid bits need reset; tags behind a cleared valid are never looked at.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    late_q <= late_d;
    rd_q   <= rd_d;
  end

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard (DEPTH=3): directed scenarios with literal
// expectations plus randomized traffic against a history-queue reference model.
module tb_forward_scoreboard;
  localparam int DEPTH = 3;
  localparam int SELW  = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic            ex_regwrite, ex_late, flush;
  logic [SELW-1:0] fwd_a, fwd_b;
  logic            stall;
`ifdef FWD_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  forward_scoreboard #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_regwrite (ex_regwrite),
    .ex_late     (ex_late),
    .flush       (flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: list of writes issued in recent cycles, youngest first.
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       late;
  } ent_t;

  ent_t hist[$];
  int   exp_a, exp_b, exp_cnt;
  bit   exp_stall;

  function automatic void lookup(input logic [4:0] rs, output int sel, output bit nr);
    sel = 0;
    nr  = 1'b0;
    if (rs == 5'd0) return;
    for (int k = 0; k < hist.size(); k++) begin
      if (hist[k].v && hist[k].rd == rs) begin
        if (k == 0 && hist[k].late) nr = 1'b1;
        else sel = k + 1;
        return;
      end
    end
  endfunction

  function automatic void model_eval();
    int sa, sb;
    bit na, nb;
    lookup(ex_rs1, sa, na);
    lookup(ex_rs2, sb, nb);
    if (ex_valid && !flush) begin
      exp_a     = sa;
      exp_b     = sb;
      exp_stall = na || nb;
    end else begin
      exp_a     = 0;
      exp_b     = 0;
      exp_stall = 1'b0;
    end
  endfunction

  function automatic void model_update();
    ent_t e;
    if (rst) begin
      hist.delete();
      exp_cnt = 0;
      return;
    end
    if (exp_stall && exp_cnt < 65535) exp_cnt++;
    e.v    = ex_valid && ex_regwrite && ex_rd != 5'd0 && !exp_stall && !flush;
    e.rd   = ex_rd;
    e.late = ex_late;
    hist.push_front(e);
    while (hist.size() > DEPTH) void'(hist.pop_back());
  endfunction

  task automatic drive(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input bit rw, input bit lt, input bit fl);
    ex_valid = v; ex_rs1 = r1; ex_rs2 = r2; ex_rd = rd;
    ex_regwrite = rw; ex_late = lt; flush = fl;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1, 5'd5, 5'd7, 5'd0, 0, 0, 0);
    checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL reset_fwd_a got=%0d exp=0", fwd_a); end
    checks++; if (fwd_b !== 2'd0) begin failures++; $display("FAIL reset_fwd_b got=%0d exp=0", fwd_b); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
`ifdef FWD_STALL_CNT_EN
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
`endif
    $display("test_reset done");
  endtask

  task automatic test_alu_back_to_back();
    do_reset();
    drive(1, 5'd0, 5'd0, 5'd5, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_issue_stall got=%0b exp=0", stall); end
    tick();
    drive(1, 5'd5, 5'd0, 5'd0, 0, 0, 0);
    checks++; if (fwd_a !== 2'd1) begin failures++; $display("FAIL b2b_fwd_a1 got=%0d exp=1", fwd_a); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%0b exp=0", stall); end
    tick();
    drive(1, 5'd5, 5'd0, 5'd0, 0, 0, 0);
    checks++; if (fwd_a !== 2'd2) begin failures++; $display("FAIL b2b_fwd_a2 got=%0d exp=2", fwd_a); end
    tick();
    $display("test_alu_back_to_back done");
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 5'd0, 5'd0, 5'd7, 1, 1, 0);
    tick();
    drive(1, 5'd0, 5'd7, 5'd0, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b exp=1", stall); end
    checks++; if (fwd_b !== 2'd0) begin failures++; $display("FAIL lu_fwd_b0 got=%0d exp=0", fwd_b); end
    tick();
    drive(1, 5'd0, 5'd7, 5'd0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_release got=%0b exp=0", stall); end
    checks++; if (fwd_b !== 2'd2) begin failures++; $display("FAIL lu_fwd_b2 got=%0d exp=2", fwd_b); end
`ifdef FWD_STALL_CNT_EN
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
`endif
    tick();
    $display("test_load_use done");
  endtask

  task automatic test_youngest_priority();
    do_reset();
    drive(1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
    tick();
    drive(1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
    tick();
    drive(1, 5'd3, 5'd3, 5'd0, 0, 0, 0);
    checks++; if (fwd_a !== 2'd1) begin failures++; $display("FAIL young_fwd_a got=%0d exp=1", fwd_a); end
    checks++; if (fwd_b !== 2'd1) begin failures++; $display("FAIL young_fwd_b got=%0d exp=1", fwd_b); end
    tick();
    // Older ready match must not hide a younger late one.
    do_reset();
    drive(1, 5'd0, 5'd0, 5'd6, 1, 0, 0);
    tick();
    drive(1, 5'd0, 5'd0, 5'd6, 1, 1, 0);
    tick();
    drive(1, 5'd6, 5'd0, 5'd0, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL nomask_stall got=%0b exp=1", stall); end
    checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL nomask_fwd_a got=%0d exp=0", fwd_a); end
    tick();
    $display("test_youngest_priority done");
  endtask

  task automatic test_x0_flush();
    do_reset();
    drive(1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    tick();
    drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL x0_fwd_a got=%0d exp=0", fwd_a); end
    drive(1, 5'd0, 5'd0, 5'd9, 1, 0, 1);
    tick();
    drive(1, 5'd9, 5'd0, 5'd0, 0, 0, 0);
    checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL flush_fwd_a got=%0d exp=0", fwd_a); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", stall); end
    // A flushed consumer of a late producer neither stalls nor forwards.
    drive(1, 5'd0, 5'd0, 5'd8, 1, 1, 0);
    tick();
    drive(1, 5'd8, 5'd8, 5'd0, 0, 0, 1);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_late_stall got=%0b exp=0", stall); end
    drive(1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL late_unflushed_stall got=%0b exp=1", stall); end
    tick();
    $display("test_x0_flush done");
  endtask

  task automatic test_retire();
    do_reset();
    drive(1, 5'd0, 5'd0, 5'd4, 1, 0, 0);
    tick();
    drive(0, 5'd4, 5'd0, 5'd0, 0, 0, 0);
    tick();
    drive(0, 5'd4, 5'd0, 5'd0, 0, 0, 0);
    tick();
    drive(1, 5'd4, 5'd0, 5'd0, 0, 0, 0);
    checks++; if (fwd_a !== 2'd3) begin failures++; $display("FAIL retire_oldest got=%0d exp=3", fwd_a); end
    tick();
    drive(1, 5'd4, 5'd4, 5'd0, 0, 0, 0);
    checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL retire_fwd_a got=%0d exp=0", fwd_a); end
    checks++; if (fwd_b !== 2'd0) begin failures++; $display("FAIL retire_fwd_b got=%0d exp=0", fwd_b); end
    tick();
    $display("test_retire done");
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 5'd0, 5'd0, 5'd7, 1, 1, 0);
    tick();
    drive(1, 5'd7, 5'd7, 5'd0, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rms_pre_stall got=%0b exp=1", stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 5'd7, 5'd7, 5'd0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rms_stall got=%0b exp=0", stall); end
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      failures++; $display("FAIL rms_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b);
    end
`ifdef FWD_STALL_CNT_EN
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rms_cnt got=%0d exp=0", stall_cnt); end
`endif
    tick();
    $display("test_reset_mid_stall done");
  endtask

  task automatic test_random(input int n);
    int errs_before;
    errs_before = failures;
    do_reset();
    for (int c = 0; c < n; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      drive($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0);
      checks++; if (int'(fwd_a) != exp_a) begin failures++; $display("FAIL rnd_fwd_a cyc=%0d got=%0d exp=%0d", c, fwd_a, exp_a); end
      checks++; if (int'(fwd_b) != exp_b) begin failures++; $display("FAIL rnd_fwd_b cyc=%0d got=%0d exp=%0d", c, fwd_b, exp_b); end
      checks++; if (stall !== exp_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", c, stall, exp_stall); end
`ifdef FWD_STALL_CNT_EN
      checks++; if (int'(stall_cnt) != exp_cnt) begin failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, stall_cnt, exp_cnt); end
`endif
      tick();
    end
    $display("test_random done cycles=%0d new_errors=%0d", n, failures - errs_before);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_regwrite = 0; ex_late = 0; flush = 0;
    test_reset();
    test_alu_back_to_back();
    test_load_use();
    test_youngest_priority();
    test_x0_flush();
    test_retire();
    test_reset_mid_stall();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
